// File: rtl/tm1637_rx_decoder.sv
// TM1637 device-side receiver: oversamples the two-wire bus, ACKs bytes,
// interprets commands and keeps a decoded model of the digit registers.
module tm1637_rx_decoder #(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tm_clk,
  input  logic                    tm_dio_in,
  output logic                    tm_dio_oe,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [2:0]              brightness,
  output logic                    display_on,
  output logic                    frame_done,
  output logic                    proto_err
);

  // Never fewer than two synchroniser flops, whatever the caller asks for.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Synchroniser and edge-detect history
  logic [SYNC_N-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_N-1:0] dio_sync_q, dio_sync_d;
  logic              clk_prev_q, clk_prev_d;
  logic              dio_prev_q, dio_prev_d;

  // Protocol state
  logic [1:0]        state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic              bit_open_q, bit_open_d;
  logic [6:0]        shift_q, shift_d;
  logic              first_q, first_d;
  logic              addr_cmd_q, addr_cmd_d;
  logic [2:0]        ptr_q, ptr_d;
  logic              fixed_q, fixed_d;
  logic              wrote_q, wrote_d;
  logic              ack_rise_q, ack_rise_d;
  logic              oe_q, oe_d;

  // Register file and outputs
  logic [NUM_DIGITS-1:0][7:0] seg_q, seg_d;
  logic [2:0]                 bright_q, bright_d;
  logic                       on_q, on_d;
  logic                       frame_q, frame_d;
  logic                       perr_q, perr_d;
  logic [4*NUM_DIGITS-1:0]    digits_q, digits_d;
  logic [NUM_DIGITS-1:0]      derr_q, derr_d;
  logic [NUM_DIGITS-1:0]      dp_q, dp_d;

  // Bus events
  logic       clk_s, dio_s;
  logic       clk_rise_c, clk_fall_c, start_c, stop_c;
  logic [7:0] byte_c;
  logic       ptr_ok_c;

  // Maps bits 6:0 of a segment byte to {digit, error}.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = {4'd0, 1'b0};
      7'h06:   r = {4'd1, 1'b0};
      7'h5B:   r = {4'd2, 1'b0};
      7'h4F:   r = {4'd3, 1'b0};
      7'h66:   r = {4'd4, 1'b0};
      7'h6D:   r = {4'd5, 1'b0};
      7'h7D:   r = {4'd6, 1'b0};
      7'h07:   r = {4'd7, 1'b0};
      7'h7F:   r = {4'd8, 1'b0};
      7'h67:   r = {4'd9, 1'b0};
      default: r = {4'hE, 1'b1};
    endcase
    return r;
  endfunction

  assign clk_s      = clk_sync_q[SYNC_N-1];
  assign dio_s      = dio_sync_q[SYNC_N-1];
  assign clk_rise_c = clk_s & ~clk_prev_q;
  assign clk_fall_c = ~clk_s & clk_prev_q;
  assign start_c    = clk_s & clk_prev_q & ~dio_s & dio_prev_q;
  assign stop_c     = clk_s & clk_prev_q & dio_s & ~dio_prev_q;
  assign byte_c     = {dio_s, shift_q};
  assign ptr_ok_c   = (32'(ptr_q) < NUM_DIGITS);

  // Shift pins through the synchroniser and remember the last synced level.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_N-2:0], tm_clk};
    dio_sync_d = {dio_sync_q[SYNC_N-2:0], tm_dio_in};
    clk_prev_d = clk_s;
    dio_prev_d = dio_s;
  end

  // Framing FSM, command interpretation and segment register writes.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    bit_open_d = bit_open_q;
    shift_d    = shift_q;
    first_d    = first_q;
    addr_cmd_d = addr_cmd_q;
    ptr_d      = ptr_q;
    fixed_d    = fixed_q;
    wrote_d    = wrote_q;
    ack_rise_d = ack_rise_q;
    oe_d       = oe_q;
    seg_d      = seg_q;
    bright_d   = bright_q;
    on_d       = on_q;
    frame_d    = 1'b0;
    perr_d     = 1'b0;

    if (start_c) begin
      // New or repeated start: any partial byte is silently dropped.
      state_d    = ST_SHIFT;
      bitcnt_d   = 3'd0;
      bit_open_d = 1'b0;
      first_d    = 1'b1;
      addr_cmd_d = 1'b0;
      wrote_d    = 1'b0;
      ack_rise_d = 1'b0;
      oe_d       = 1'b0;
    end else if (stop_c) begin
      // The rise that sets up a STOP is not a data bit, so only bits
      // closed by a falling edge count as a truncated byte.
      if (state_q == ST_SHIFT && (bitcnt_q - 3'(bit_open_q)) != 3'd0) begin
        perr_d = 1'b1;
      end
      frame_d    = wrote_q;
      state_d    = ST_IDLE;
      wrote_d    = 1'b0;
      ack_rise_d = 1'b0;
      oe_d       = 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (clk_fall_c) begin
            bit_open_d = 1'b0;
          end else if (clk_rise_c) begin
            shift_d = {dio_s, shift_q[6:1]};
            if (bitcnt_q != 3'd7) begin
              bitcnt_d   = 3'(bitcnt_q + 3'd1);
              bit_open_d = 1'b1;
            end else begin
              bitcnt_d   = 3'd0;
              bit_open_d = 1'b0;
              first_d    = 1'b0;
              ack_rise_d = 1'b0;
              state_d    = ST_ACK;
              if (first_q) begin
                case (byte_c[7:6])
                  2'b01: fixed_d = byte_c[2];
                  2'b11: begin
                    ptr_d      = byte_c[2:0];
                    addr_cmd_d = 1'b1;
                  end
                  2'b10: begin
                    on_d     = byte_c[3];
                    bright_d = byte_c[2:0];
                  end
                  default: begin
                    perr_d  = 1'b1;
                    state_d = ST_DRAIN;
                  end
                endcase
              end else if (addr_cmd_q) begin
                if (ptr_ok_c) begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (32'(ptr_q) == 32'(i)) seg_d[i] = byte_c;
                  end
                  wrote_d = 1'b1;
                  if (!fixed_q && ptr_q != 3'd7) ptr_d = 3'(ptr_q + 3'd1);
                end else begin
                  // Out-of-range data is dropped but still acknowledged.
                  perr_d = 1'b1;
                end
              end else begin
                perr_d  = 1'b1;
                state_d = ST_DRAIN;
              end
            end
          end
        end
        ST_ACK: begin
          // Pull DIO low from the 8th fall until the fall after the 9th rise.
          if (clk_fall_c) begin
            if (ack_rise_q) begin
              oe_d       = 1'b0;
              ack_rise_d = 1'b0;
              state_d    = ST_SHIFT;
            end else begin
              oe_d = 1'b1;
            end
          end else if (clk_rise_c && oe_q) begin
            ack_rise_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decode the next segment contents into registered digit outputs.
  always_comb begin
    digits_d = '0;
    derr_d   = '0;
    dp_d     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      {digits_d[4*i +: 4], derr_d[i]} = seg_decode(seg_d[i][6:0]);
      dp_d[i] = seg_d[i][7];
    end
  end

  // State and output registers; the synchroniser idles at bus-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dio_sync_q <= '1;
      clk_prev_q <= 1'b1;
      dio_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      bit_open_q <= 1'b0;
      shift_q    <= '0;
      first_q    <= 1'b0;
      addr_cmd_q <= 1'b0;
      ptr_q      <= 3'd0;
      fixed_q    <= 1'b0;
      wrote_q    <= 1'b0;
      ack_rise_q <= 1'b0;
      oe_q       <= 1'b0;
      seg_q      <= '0;
      bright_q   <= 3'd0;
      on_q       <= 1'b0;
      frame_q    <= 1'b0;
      perr_q     <= 1'b0;
      digits_q   <= {NUM_DIGITS{4'hE}};
      derr_q     <= '1;
      dp_q       <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dio_sync_q <= dio_sync_d;
      clk_prev_q <= clk_prev_d;
      dio_prev_q <= dio_prev_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      bit_open_q <= bit_open_d;
      shift_q    <= shift_d;
      first_q    <= first_d;
      addr_cmd_q <= addr_cmd_d;
      ptr_q      <= ptr_d;
      fixed_q    <= fixed_d;
      wrote_q    <= wrote_d;
      ack_rise_q <= ack_rise_d;
      oe_q       <= oe_d;
      seg_q      <= seg_d;
      bright_q   <= bright_d;
      on_q       <= on_d;
      frame_q    <= frame_d;
      perr_q     <= perr_d;
      digits_q   <= digits_d;
      derr_q     <= derr_d;
      dp_q       <= dp_d;
    end
  end

  assign tm_dio_oe  = oe_q;
  assign digits     = digits_q;
  assign digit_err  = derr_q;
  assign dp         = dp_q;
  assign brightness = bright_q;
  assign display_on = on_q;
  assign frame_done = frame_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_tm1637_rx_decoder.sv
// Bench for tm1637_rx_decoder: directed vector table, corner sequences and
// random transactions scored against a transaction-level display model.
module tb_tm1637_rx_decoder;

  localparam int ND = 6;
  localparam int P  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_clk = 1'b1;
  logic drv_dio = 1'b1;
  logic tm_dio_in;
  logic tm_dio_oe;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_err, dp;
  logic [2:0] brightness;
  logic display_on, frame_done, proto_err;

  // Open-drain pin: low when either side pulls it.
  assign tm_dio_in = drv_dio & ~tm_dio_oe;

  tm1637_rx_decoder #(.NUM_DIGITS(ND), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tm_clk(drv_clk), .tm_dio_in(tm_dio_in),
    .tm_dio_oe(tm_dio_oe), .digits(digits), .digit_err(digit_err), .dp(dp),
    .brightness(brightness), .display_on(display_on),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int perr_cnt = 0, fd_cnt = 0;

  always @(negedge clk) begin
    if (proto_err)  perr_cnt <= perr_cnt + 1;
    if (frame_done) fd_cnt   <= fd_cnt + 1;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
  logic [7:0] m_seg [ND];
  int         m_ptr;
  bit         m_fixed;
  logic [2:0] m_bri;
  bit         m_on;
  int         exp_ack[$];
  int         exp_perr, exp_fd;

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) m_seg[i] = 8'h00;
    m_ptr = 0; m_fixed = 0; m_bri = 3'd0; m_on = 0;
  endfunction

  function automatic void model_txn(input logic [7:0] bq[$]);
    bit drain = 0;
    bit addr = 0;
    bit wrote = 0;
    exp_ack.delete();
    exp_perr = 0;
    foreach (bq[k]) begin
      if (drain) exp_ack.push_back(0);
      else if (k == 0) begin
        case (bq[k][7:6])
          2'b01: begin m_fixed = bq[k][2]; exp_ack.push_back(1); end
          2'b11: begin m_ptr = int'(bq[k][2:0]); addr = 1; exp_ack.push_back(1); end
          2'b10: begin m_on = bq[k][3]; m_bri = bq[k][2:0]; exp_ack.push_back(1); end
          default: begin exp_perr++; drain = 1; exp_ack.push_back(0); end
        endcase
      end else if (!addr) begin
        exp_perr++; drain = 1; exp_ack.push_back(0);
      end else begin
        if (m_ptr < ND) begin
          m_seg[m_ptr] = bq[k];
          wrote = 1;
          if (!m_fixed && m_ptr < 7) m_ptr++;
        end else exp_perr++;
        exp_ack.push_back(1);
      end
    end
    exp_fd = wrote ? 1 : 0;
  endfunction

  function automatic logic [4*ND-1:0] m_digits();
    logic [4*ND-1:0] d = '0;
    for (int i = 0; i < ND; i++) begin
      d[4*i +: 4] = 4'hE;
      for (int j = 0; j < 10; j++) if (m_seg[i][6:0] == pat[j]) d[4*i +: 4] = 4'(j);
    end
    return d;
  endfunction

  function automatic logic [ND-1:0] m_err();
    logic [ND-1:0] e = '1;
    for (int i = 0; i < ND; i++)
      for (int j = 0; j < 10; j++) if (m_seg[i][6:0] == pat[j]) e[i] = 1'b0;
    return e;
  endfunction

  function automatic logic [ND-1:0] m_dp();
    logic [ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[i] = m_seg[i][7];
    return r;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, " digits"}, 32'(digits), 32'(m_digits()));
    chk({tag, " digit_err"}, 32'(digit_err), 32'(m_err()));
    chk({tag, " dp"}, 32'(dp), 32'(m_dp()));
    chk({tag, " brightness"}, 32'(brightness), 32'(m_bri));
    chk({tag, " display_on"}, 32'(display_on), 32'(m_on));
  endtask

  // ---------------- bus driver ----------------
  task automatic wait_p();
    repeat (P) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!(drv_clk && drv_dio)) begin
      drv_clk = 1'b0; wait_p();
      drv_dio = 1'b1; wait_p();
      drv_clk = 1'b1; wait_p();
    end
    drv_dio = 1'b0; wait_p();
  endtask

  task automatic bus_stop();
    drv_clk = 1'b0; wait_p();
    drv_dio = 1'b0; wait_p();
    drv_clk = 1'b1; wait_p();
    drv_dio = 1'b1; wait_p();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output bit early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      drv_clk = 1'b0; wait_p();
      drv_dio = b[i]; wait_p();
      drv_clk = 1'b1; wait_p();
      if (tm_dio_oe) early = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int ack, input string tag);
    bit early, a1, a2, a3;
    send_bits(b, 8, early);
    drv_clk = 1'b0; wait_p();
    drv_dio = 1'b1; wait_p();
    a1 = tm_dio_oe;
    drv_clk = 1'b1; wait_p();
    a2 = tm_dio_oe;
    drv_clk = 1'b0; wait_p();
    a3 = tm_dio_oe;
    chk(tag, 32'({early, a1, a2, a3}), (ack != 0) ? 32'h6 : 32'h0);
  endtask

  task automatic run_txn(input logic [7:0] bq[$], input string tag, output int dperr, output int dfd);
    int p0, f0;
    p0 = perr_cnt; f0 = fd_cnt;
    model_txn(bq);
    bus_start();
    foreach (bq[k]) send_byte(bq[k], exp_ack[k], $sformatf("%s ack%0d", tag, k));
    bus_stop();
    dperr = perr_cnt - p0;
    dfd = fd_cnt - f0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; drv_clk = 1'b1; drv_dio = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " oe"}, 32'(tm_dio_oe), 32'h0);
    chk({tag, " digits"}, 32'(digits), 32'hEEEEEE);
    chk({tag, " digit_err"}, 32'(digit_err), 32'h3F);
    chk({tag, " dp"}, 32'(dp), 32'h0);
    chk({tag, " brightness"}, 32'(brightness), 32'h0);
    chk({tag, " display_on"}, 32'(display_on), 32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit              rst;
    int              n;
    logic [63:0]     b;     // byte k at [8k+7:8k]
    logic [4*ND-1:0] dig;
    logic [ND-1:0]   err;
    logic [ND-1:0]   dpx;
    logic [2:0]      bri;
    bit              on;
    int              perr;
    int              fd;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [7:0] q[$];
    int dperr, dfd, p0, f0, nd, r;
    bit early;
    logic [7:0] cmd, db;

    vt[0]  = '{0, 1, 64'h40,               24'hEEEEEE, 6'h3F, 6'h00, 3'd0, 1'b0, 0, 0};
    vt[1]  = '{0, 7, 64'h006D664F5B063FC0, 24'h543210, 6'h00, 6'h00, 3'd0, 1'b0, 0, 1};
    vt[2]  = '{1, 1, 64'h44,               24'hEEEEEE, 6'h3F, 6'h00, 3'd0, 1'b0, 0, 0};
    vt[3]  = '{0, 3, 64'hE77FC3,           24'hEE9EEE, 6'h37, 6'h08, 3'd0, 1'b0, 0, 1};
    vt[4]  = '{0, 1, 64'h8F,               24'hEE9EEE, 6'h37, 6'h08, 3'd7, 1'b1, 0, 0};
    vt[5]  = '{0, 1, 64'h80,               24'hEE9EEE, 6'h37, 6'h08, 3'd0, 1'b0, 0, 0};
    vt[6]  = '{0, 1, 64'h40,               24'hEE9EEE, 6'h37, 6'h08, 3'd0, 1'b0, 0, 0};
    vt[7]  = '{0, 3, 64'h063FC5,           24'h0E9EEE, 6'h17, 6'h08, 3'd0, 1'b0, 1, 1};
    vt[8]  = '{0, 2, 64'h3F12,             24'h0E9EEE, 6'h17, 6'h08, 3'd0, 1'b0, 1, 0};
    vt[9]  = '{0, 2, 64'h3FC0,             24'h0E9EE0, 6'h16, 6'h08, 3'd0, 1'b0, 0, 1};
    vt[10] = '{0, 2, 64'h79C0,             24'h0E9EEE, 6'h17, 6'h08, 3'd0, 1'b0, 0, 1};

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset frame_done", 32'(frame_done), 32'h0);
    chk("reset proto_err", 32'(proto_err), 32'h0);

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vt[i].rst) do_reset();
      q.delete();
      for (int k = 0; k < vt[i].n; k++) q.push_back(vt[i].b[8*k +: 8]);
      run_txn(q, tag, dperr, dfd);
      chk({tag, " digits"}, 32'(digits), 32'(vt[i].dig));
      chk({tag, " digit_err"}, 32'(digit_err), 32'(vt[i].err));
      chk({tag, " dp"}, 32'(dp), 32'(vt[i].dpx));
      chk({tag, " brightness"}, 32'(brightness), 32'(vt[i].bri));
      chk({tag, " display_on"}, 32'(display_on), 32'(vt[i].on));
      chk({tag, " proto_err pulses"}, 32'(dperr), 32'(vt[i].perr));
      chk({tag, " frame_done pulses"}, 32'(dfd), 32'(vt[i].fd));
    end

    // STOP after five bits of a byte is a truncated byte.
    p0 = perr_cnt; f0 = fd_cnt;
    bus_start();
    send_bits(8'h1F, 5, early);
    bus_stop();
    chk("stop5 proto_err pulses", 32'(perr_cnt - p0), 32'd1);
    chk("stop5 frame_done pulses", 32'(fd_cnt - f0), 32'd0);
    chk_model("stop5");

    // Repeated START after three bits discards them without an error.
    q.delete(); q.push_back(8'hC1); q.push_back(8'h06);
    p0 = perr_cnt; f0 = fd_cnt;
    model_txn(q);
    bus_start();
    send_bits(8'h05, 3, early);
    bus_start();
    foreach (q[k]) send_byte(q[k], exp_ack[k], $sformatf("rstart ack%0d", k));
    bus_stop();
    chk("rstart proto_err pulses", 32'(perr_cnt - p0), 32'd0);
    chk("rstart frame_done pulses", 32'(fd_cnt - f0), 32'd1);
    chk("rstart digits", 32'(digits), 32'h0E9E1E);
    chk_model("rstart");

    // Reset asserted while the device is driving the ACK.
    q.delete(); q.push_back(8'h8A);
    run_txn(q, "pre_rst", dperr, dfd);
    chk("pre_rst display_on", 32'(display_on), 32'h1);
    bus_start();
    send_bits(8'hC0, 8, early);
    drv_clk = 1'b0; wait_p();
    chk("ack before reset oe", 32'(tm_dio_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    drv_dio = 1'b1; drv_clk = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    chk_reset_vals("post_rst");

    // Random transactions against the model.
    for (int t = 0; t < 16; t++) begin
      string tag;
      tag = $sformatf("rnd%0d", t);
      r = $urandom_range(0, 9);
      if (r < 2)      cmd = {2'b01, 3'($urandom), 1'($urandom), 2'($urandom)};
      else if (r < 7) cmd = {2'b11, 3'($urandom), 3'($urandom)};
      else if (r < 9) cmd = {2'b10, 2'($urandom), 4'($urandom)};
      else            cmd = {2'b00, 6'($urandom)};
      q.delete(); q.push_back(cmd);
      nd = $urandom_range(0, 4);
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 3) != 0) db = {1'($urandom), pat[$urandom_range(0, 9)]};
        else db = 8'($urandom);
        q.push_back(db);
      end
      run_txn(q, tag, dperr, dfd);
      chk({tag, " proto_err pulses"}, 32'(dperr), 32'(exp_perr));
      chk({tag, " frame_done pulses"}, 32'(dfd), 32'(exp_fd));
      chk_model(tag);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
